wb_commit_unit: RTL
===================

Name: wb_commit_unit

Overview:
- Final pipeline stage (MEM3→WB) and the producer side of the decode-stage writeback interface.
- Takes retiring results from MEM3: ALU/CSR results, and load data returned by the data cache.
- Aligns and sign/zero-extends load data, holds while the data cache is not ready, and drives the register-file write triple (TYPE_MEM3_WB, WB_DES, WB_DATA) back to the decode unit.
- Also reports its own stall state upstream.

Parameters:
- XLEN, 32, datapath width
- RF_ADDR_W, 5, register index width

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- IN_VALID  in  1  MEM3 presents a retiring instruction
- IN_TYPE  in  2  op type: idle=2'b00, alu=2'b01, load=2'b10, store=2'b11
- IN_RD  in  5  destination register
- IN_FUN3  in  3  load width/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5)
- IN_ADDR_LO  in  2  byte offset of load address
- IN_RESULT  in  32  ALU/CSR result
- DATA_CACHE_READY  in  1  D-cache response valid for the current load
- DCACHE_RDATA  in  32  D-cache read word
- FLUSH  in  1  kill the instruction currently accepted at the input
- IN_READY  out  1  stage can accept IN_* this cycle
- TYPE_MEM3_WB  out  2  writeback type; anything other than idle means write enable
- WB_DES  out  5  destination register
- WB_DATA  out  32  writeback data
- WB_STALL  out  1  high while waiting on the D-cache

Behaviour:
- Reset (RST=0, asynchronous):
  - TYPE_MEM3_WB=idle, WB_DES=0, WB_DATA=0, WB_STALL=0, IN_READY=1.
  - FSM to IDLE.
  - A reset mid-load discards the load.
- FSM states: IDLE, WAIT_LOAD, COMMIT.
- IDLE:
  - Accept when IN_VALID & IN_READY & !FLUSH.
  - alu → COMMIT, with result registered.
  - store → COMMIT, but emitted as idle (stores never write the register file).
  - load with DATA_CACHE_READY=1 in the same cycle → COMMIT with extended data.
  - load with DATA_CACHE_READY=0 → WAIT_LOAD, capturing rd/fun3/addr_lo.
- WAIT_LOAD:
  - WB_STALL=1 and IN_READY=0.
  - On DATA_CACHE_READY=1: extend DCACHE_RDATA, go to COMMIT.
  - FLUSH is ignored here; the load is already architecturally committed.
- COMMIT:
  - Outputs are valid for exactly one cycle.
  - Returns to IDLE, or accepts the next instruction in that same cycle (back-to-back throughput 1/cycle for alu).
- Latency:
  - alu/store: 1 cycle from acceptance to TYPE_MEM3_WB.
  - load: 1 cycle after DATA_CACHE_READY.
- Outputs are registered. In every cycle with no commit, TYPE_MEM3_WB=idle; WB_DES and WB_DATA hold their last values.
- rd=0: the block commits normally with WB_DES=0; the register file ignores x0.
- Load extension:
  - The selected byte/half is DCACHE_RDATA >> (8*addr_lo).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
  - Misaligned LH (addr_lo=3) and misaligned LW (addr_lo≠0): data is the raw shifted word, with the same zero-extension rule as a 32-bit pass-through. No trap is raised here.
- FLUSH coincident with IN_VALID in IDLE: the instruction is dropped and no commit occurs.
- Undefined IN_FUN3 on a load: treated as LW.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output RETIRE_CNT [63:0], counting one per COMMIT-state cycle (stores included).
  - Reset to 0; wraps at 2^64−1 → 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header (extends PipelineParams.vh):
  - op type encodings idle/alu/load/store
  - FUN3 load encodings
  - FSM state encodings
- Sub-module: load_align_ext. Combinational; inputs word, addr_lo, fun3; output 32-bit result. Instantiated once in the commit path.

Test Plan:
- ALU commit: IN_TYPE=alu, rd=5, result=0xDEADBEEF → next cycle TYPE_MEM3_WB=alu, WB_DES=5, WB_DATA=0xDEADBEEF; idle the cycle after.
- LB sign-extend: load, fun3=0, addr_lo=2, rdata=0x0080_0000, ready same cycle → WB_DATA=0xFFFFFF80.
- LHU with wait: load, fun3=5, addr_lo=2, ready low 3 cycles then rdata=0xFFEE_1234 →
  - WB_STALL high 3 cycles, IN_READY low;
  - then WB_DATA=0x0000FFEE.
- Store suppression: IN_TYPE=store, rd=7 → TYPE_MEM3_WB stays idle; RETIRE_CNT (if enabled) +1.
- Flush on accept: IN_VALID=1, FLUSH=1, alu → no commit. FLUSH during WAIT_LOAD → the load still commits.
- Async reset: assert RST=0 mid-WAIT_LOAD → outputs zero/idle immediately (no clock edge needed); after release, a new alu instruction commits normally.

Source files
------------

// File: rtl/wb_commit_unit_pkg.sv
// Shared encodings for the MEM3->WB commit stage: op types, load FUN3 codes, FSM states.
// Used by wb_commit_unit and load_align_ext.
package wb_commit_unit_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_type_e;

    localparam logic [2:0] FUN3_LB  = 3'd0;
    localparam logic [2:0] FUN3_LH  = 3'd1;
    localparam logic [2:0] FUN3_LW  = 3'd2;
    localparam logic [2:0] FUN3_LBU = 3'd4;
    localparam logic [2:0] FUN3_LHU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_COMMIT    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_align_ext.sv
// Combinational load aligner: shifts the D-cache word down by the byte offset,
// then sign/zero-extends the selected byte or half according to FUN3.
module load_align_ext
    import wb_commit_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      fun3,
    output logic [XLEN-1:0] result
);

    logic [7:0]      lane [XLEN/8];
    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
        assign lane[gi] = word[8*gi +: 8];
    end

    assign shifted  = word >> {addr_lo, 3'b000};
    assign byte_sel = lane[addr_lo];
    assign half_sel = shifted[15:0];

    always_comb begin
        result = shifted;
        case (fun3)
            FUN3_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            // A half starting at the last byte has only one real byte; pass it through unextended.
            FUN3_LH:  result = (addr_lo == 2'd3) ? shifted
                                                 : {{(XLEN-16){half_sel[15]}}, half_sel};
            FUN3_LW:  result = shifted;
            FUN3_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
            FUN3_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// MEM3->WB commit stage driving the register-file write triple back to decode.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic [1:0]           IN_TYPE,
    input  logic [RF_ADDR_W-1:0] IN_RD,
    input  logic [2:0]           IN_FUN3,
    input  logic [1:0]           IN_ADDR_LO,
    input  logic [XLEN-1:0]      IN_RESULT,
    input  logic                 DATA_CACHE_READY,
    input  logic [XLEN-1:0]      DCACHE_RDATA,
    input  logic                 FLUSH,
    output logic                 IN_READY,
    output logic [1:0]           TYPE_MEM3_WB,
    output logic [RF_ADDR_W-1:0] WB_DES,
    output logic [XLEN-1:0]      WB_DATA,
    output logic                 WB_STALL
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]          RETIRE_CNT
`endif
);

    wb_state_e             state_q, state_d;
    op_type_e              type_q, type_d;
    logic [RF_ADDR_W-1:0]  des_q, des_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [RF_ADDR_W-1:0]  rd_q, rd_d;
    logic [2:0]            fun3_q, fun3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;

    logic                  in_ready;
    logic                  accept;
    logic [1:0]            ext_addr_lo;
    logic [2:0]            ext_fun3;
    logic [XLEN-1:0]       ext_data;

    assign in_ready = (state_q != S_WAIT_LOAD);
    assign accept   = IN_VALID && in_ready && !FLUSH;

    // One aligner serves both the same-cycle hit and the delayed response.
    assign ext_addr_lo = (state_q == S_WAIT_LOAD) ? addr_lo_q : IN_ADDR_LO;
    assign ext_fun3    = (state_q == S_WAIT_LOAD) ? fun3_q    : IN_FUN3;

    load_align_ext #(.XLEN(XLEN)) u_align (
        .word    (DCACHE_RDATA),
        .addr_lo (ext_addr_lo),
        .fun3    (ext_fun3),
        .result  (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        type_d    = OP_IDLE;
        des_d     = des_q;
        data_d    = data_q;
        rd_d      = rd_q;
        fun3_d    = fun3_q;
        addr_lo_d = addr_lo_q;
        case (state_q)
            S_IDLE, S_COMMIT: begin
                state_d = S_IDLE;
                if (accept) begin
                    case (op_type_e'(IN_TYPE))
                        OP_ALU: begin
                            state_d = S_COMMIT;
                            type_d  = OP_ALU;
                            des_d   = IN_RD;
                            data_d  = IN_RESULT;
                        end
                        // Stores retire through COMMIT but never write the register file.
                        OP_STORE: state_d = S_COMMIT;
                        OP_LOAD: begin
                            if (DATA_CACHE_READY) begin
                                state_d = S_COMMIT;
                                type_d  = OP_LOAD;
                                des_d   = IN_RD;
                                data_d  = ext_data;
                            end else begin
                                state_d   = S_WAIT_LOAD;
                                rd_d      = IN_RD;
                                fun3_d    = IN_FUN3;
                                addr_lo_d = IN_ADDR_LO;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WAIT_LOAD: begin
                if (DATA_CACHE_READY) begin
                    state_d = S_COMMIT;
                    type_d  = OP_LOAD;
                    des_d   = rd_q;
                    data_d  = ext_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            type_q    <= OP_IDLE;
            des_q     <= '0;
            data_q    <= '0;
            rd_q      <= '0;
            fun3_q    <= '0;
            addr_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            des_q     <= des_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            fun3_q    <= fun3_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    assign IN_READY     = in_ready;
    assign TYPE_MEM3_WB = type_q;
    assign WB_DES       = des_q;
    assign WB_DATA      = data_q;
    assign WB_STALL     = (state_q == S_WAIT_LOAD);

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (state_q == S_COMMIT) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign RETIRE_CNT = retire_cnt_q;
`endif

endmodule
